// File: rtl/memory_stage.sv
// Memory/IO stage: issues data-memory loads and stores, UART receive and transmit,
// and produces a single registered writeback pulse per accepted instruction.
module memory_stage #(
  parameter int unsigned DATA_MEM_WIDTH = 10,
  parameter int unsigned MEM_LATENCY    = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [31:0]               result,
  input  logic [31:0]               register_data,
  input  logic [4:0]                rdist,
  input  logic [DATA_MEM_WIDTH-1:0] link,
  output logic                      stall,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  input  logic [7:0]                uart_rx_data,
  input  logic                      uart_rx_valid,
  output logic                      uart_rx_ready,
  output logic [7:0]                uart_tx_data,
  output logic                      uart_tx_valid,
  input  logic                      uart_tx_ready,
  output logic                      wb_valid,
  output logic                      RegWrite_wb,
  output logic [4:0]                rdist_wb,
  output logic [31:0]               wb_data
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, RX_WAIT, TX_WAIT} state_e;

  state_e                    state_q;
  logic                      stall_q;
  logic [DATA_MEM_WIDTH-1:0] mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic                      mem_we_q;
  logic                      mem_re_q;
  logic                      rx_ready_q;
  logic [7:0]                tx_data_q;
  logic                      tx_valid_q;
  logic                      wb_valid_q;
  logic                      regwrite_wb_q;
  logic [4:0]                rdist_wb_q;
  logic [31:0]               wb_data_q;
  logic [31:0]               pend_data_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      accept_c;
  logic [31:0]               sel_data_d;

  assign accept_c = valid_in & ~stall_q;

  // Immediate writeback value; the memory select reflects the live read bus.
  always_comb begin
    sel_data_d = result;
    case (MemtoReg)
      2'b01:   sel_data_d = mem_rdata;
      2'b10:   sel_data_d = 32'(link);
      default: sel_data_d = result;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      stall_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      rx_ready_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      regwrite_wb_q <= 1'b0;
      rdist_wb_q    <= '0;
      wb_data_q     <= '0;
      pend_data_q   <= '0;
      cnt_q         <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            rdist_wb_q    <= rdist;
            regwrite_wb_q <= RegWrite & (rdist != 5'd0);
            if (MemRead) begin
              mem_addr_q <= result[DATA_MEM_WIDTH+1:2];
              mem_re_q   <= 1'b1;
              cnt_q      <= '0;
              stall_q    <= 1'b1;
              state_q    <= MEM_WAIT;
            end else if (UARTtoReg) begin
              rx_ready_q <= 1'b1;
              stall_q    <= 1'b1;
              state_q    <= RX_WAIT;
            end else if (RegtoUART) begin
              tx_data_q   <= register_data[7:0];
              tx_valid_q  <= 1'b1;
              pend_data_q <= sel_data_d;
              stall_q     <= 1'b1;
              state_q     <= TX_WAIT;
            end else if (MemWrite) begin
              mem_addr_q  <= result[DATA_MEM_WIDTH+1:2];
              mem_wdata_q <= register_data;
              mem_we_q    <= 1'b1;
              wb_valid_q  <= 1'b1;
              wb_data_q   <= sel_data_d;
            end else begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= sel_data_d;
            end
          end
        end
        // Counter starts at zero in the mem_re cycle; read data is valid when it hits the latency.
        MEM_WAIT: begin
          if (cnt_q == CNT_W'(MEM_LATENCY)) begin
            wb_data_q  <= mem_rdata;
            wb_valid_q <= 1'b1;
            stall_q    <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_WAIT: begin
          if (uart_rx_valid) begin
            wb_data_q  <= {24'b0, uart_rx_data};
            wb_valid_q <= 1'b1;
            rx_ready_q <= 1'b0;
            stall_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        TX_WAIT: begin
          if (uart_tx_ready) begin
            wb_data_q  <= pend_data_q;
            wb_valid_q <= 1'b1;
            tx_valid_q <= 1'b0;
            stall_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall         = stall_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign uart_rx_ready = rx_ready_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign wb_valid      = wb_valid_q;
  assign RegWrite_wb   = regwrite_wb_q;
  assign rdist_wb      = rdist_wb_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table for single-cycle ops plus
// hand sequences for load latency, UART handshakes and mid-wait reset.
module tb_memory_stage;

  localparam int unsigned AW = 10;

  logic          CLK, reset, valid_in, RegWrite, MemWrite, MemRead, UARTtoReg, RegtoUART;
  logic [1:0]    MemtoReg;
  logic [31:0]   result, register_data, mem_rdata, mem_wdata, wb_data;
  logic [4:0]    rdist, rdist_wb;
  logic [AW-1:0] link, mem_addr;
  logic          stall, mem_we, mem_re, uart_rx_ready, uart_rx_valid;
  logic          uart_tx_valid, uart_tx_ready, wb_valid, RegWrite_wb;
  logic [7:0]    uart_rx_data, uart_tx_data;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DATA_MEM_WIDTH(AW), .MEM_LATENCY(2)) dut (
    .CLK(CLK), .reset(reset), .valid_in(valid_in), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART), .result(result),
    .register_data(register_data), .rdist(rdist), .link(link), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .wb_valid(wb_valid), .RegWrite_wb(RegWrite_wb), .rdist_wb(rdist_wb),
    .wb_data(wb_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory with a two-cycle read pipeline; off-cycle reads return a poison word.
  logic [31:0]   tb_mem [0:1023];
  logic          p1_v, p2_v;
  logic [AW-1:0] p1_a, p2_a;
  always @(posedge CLK) begin
    if (reset) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
    end else begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      p1_v <= mem_re;
      p1_a <= mem_addr;
      p2_v <= p1_v;
      p2_a <= p1_a;
    end
  end
  assign mem_rdata = p2_v ? tb_mem[p2_a] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe exclusivity is checked every cycle.
  always @(negedge CLK) begin
    if (!reset && (32'(mem_we) + 32'(mem_re) + 32'(uart_rx_ready) + 32'(uart_tx_valid)) > 1)
      chk("strobe_exclusive", {28'b0, mem_we, mem_re, uart_rx_ready, uart_tx_valid}, 32'h0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ops();
    valid_in = 0; RegWrite = 0; MemtoReg = 2'b00; MemWrite = 0; MemRead = 0;
    UARTtoReg = 0; RegtoUART = 0;
  endtask

  typedef struct {
    logic          valid, mw, rw;
    logic [1:0]    sel;
    logic [31:0]   res, rdata;
    logic [4:0]    rd;
    logic [AW-1:0] lnk;
    logic          e_wbv;
    logic [31:0]   e_wbd;
    logic          e_rw;
    logic [4:0]    e_rd;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    clear_ops();
    result = 0; register_data = 0; rdist = 0; link = 0;
    uart_rx_data = 0; uart_rx_valid = 0; uart_tx_ready = 0;
    reset = 1;

    vecs[0] = '{1, 0, 1, 2'b00, 32'h0000_0123, 32'h0, 5'd5, 10'h0,   1, 32'h0000_0123, 1, 5'd5,  0, 10'h0,   32'h0};
    vecs[1] = '{1, 0, 1, 2'b10, 32'hCAFE_F00D, 32'h0, 5'd31, 10'h3FF, 1, 32'h0000_03FF, 1, 5'd31, 0, 10'h0,   32'h0};
    vecs[2] = '{1, 0, 0, 2'b11, 32'h8000_0001, 32'h0, 5'd7, 10'h0,   1, 32'h8000_0001, 0, 5'd7,  0, 10'h0,   32'h0};
    vecs[3] = '{1, 0, 1, 2'b00, 32'h0000_0ABC, 32'h0, 5'd0, 10'h0,   1, 32'h0000_0ABC, 0, 5'd0,  0, 10'h0,   32'h0};
    vecs[4] = '{1, 1, 0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 10'h0, 1, 32'h0000_0010, 0, 5'd0, 1, 10'h004, 32'hDEAD_BEEF};
    vecs[5] = '{1, 1, 1, 2'b00, 32'h0000_0FFC, 32'h5A5A_1234, 5'd2, 10'h0, 1, 32'h0000_0FFC, 1, 5'd2, 1, 10'h3FF, 32'h5A5A_1234};
    vecs[6] = '{1, 1, 1, 2'b00, 32'hFFFF_F004, 32'h0BAD_F00D, 5'd3, 10'h0, 1, 32'hFFFF_F004, 1, 5'd3, 1, 10'h001, 32'h0BAD_F00D};
    vecs[7] = '{0, 1, 0, 2'b00, 32'h0000_0999, 32'h1111_1111, 5'd9, 10'h0, 0, 32'hFFFF_F004, 1, 5'd3, 0, 10'h0, 32'h0};

    tick(); tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_strobes", {28'b0, mem_we, mem_re, uart_rx_ready, uart_tx_valid}, 0);
    reset = 0;
    tick();

    // Single-cycle ALU/store vectors
    for (int i = 0; i < 8; i++) begin
      valid_in = vecs[i].valid; MemWrite = vecs[i].mw; RegWrite = vecs[i].rw;
      MemtoReg = vecs[i].sel; result = vecs[i].res; register_data = vecs[i].rdata;
      rdist = vecs[i].rd; link = vecs[i].lnk;
      tick();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wbd);
      chk($sformatf("v%0d_regwrite_wb", i), 32'(RegWrite_wb), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_rdist_wb", i), 32'(rdist_wb), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_stall", i), 32'(stall), 0);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      end
      clear_ops();
      tick();
      chk($sformatf("v%0d_wb_pulse", i), 32'(wb_valid), 0);
      chk($sformatf("v%0d_we_pulse", i), 32'(mem_we), 0);
    end

    // Load of address 4 with MemWrite also set: decoded as a load; valid_in during stall ignored
    MemRead = 1; MemWrite = 1; valid_in = 1; RegWrite = 1; rdist = 5'd9;
    result = 32'h10; register_data = 32'h7777_7777;
    tick();
    chk("ld_mem_re", 32'(mem_re), 1);
    chk("ld_mem_we", 32'(mem_we), 0);
    chk("ld_mem_addr", 32'(mem_addr), 32'h4);
    chk("ld_stall1", 32'(stall), 1);
    clear_ops();
    valid_in = 1; RegWrite = 1; result = 32'h0000_0F0F; rdist = 5'd1;
    for (int c = 2; c <= 3; c++) begin
      tick();
      chk($sformatf("ld_stall%0d", c), 32'(stall), 1);
      chk($sformatf("ld_wbv%0d", c), 32'(wb_valid), 0);
      chk($sformatf("ld_re%0d", c), 32'(mem_re), 0);
      chk($sformatf("ld_we%0d", c), 32'(mem_we), 0);
    end
    tick();
    clear_ops();
    chk("ld_wb_valid", 32'(wb_valid), 1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_rdist_wb", 32'(rdist_wb), 9);
    chk("ld_regwrite_wb", 32'(RegWrite_wb), 1);
    chk("ld_stall_done", 32'(stall), 0);
    tick();
    chk("ld_wb_pulse", 32'(wb_valid), 0);
    chk("ld_ignored_op", wb_data, 32'hDEAD_BEEF);

    // UART receive after five idle cycles
    UARTtoReg = 1; valid_in = 1; RegWrite = 1; rdist = 5'd12;
    tick();
    clear_ops();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rx_stall%0d", c), 32'(stall), 1);
      chk($sformatf("rx_ready%0d", c), 32'(uart_rx_ready), 1);
      chk($sformatf("rx_wbv%0d", c), 32'(wb_valid), 0);
      tick();
    end
    uart_rx_valid = 1; uart_rx_data = 8'h41;
    chk("rx_ready_xfer", 32'(uart_rx_ready), 1);
    tick();
    uart_rx_valid = 0;
    chk("rx_wb_valid", 32'(wb_valid), 1);
    chk("rx_wb_data", wb_data, 32'h0000_0041);
    chk("rx_rdist_wb", 32'(rdist_wb), 12);
    chk("rx_ready_off", 32'(uart_rx_ready), 0);
    chk("rx_stall_off", 32'(stall), 0);
    tick();
    chk("rx_wb_pulse", 32'(wb_valid), 0);

    // UART transmit with three not-ready cycles; data must not follow register_data
    RegtoUART = 1; valid_in = 1; RegWrite = 1; rdist = 5'd4;
    register_data = 32'h1234_56AB; result = 32'h0000_0077;
    tick();
    clear_ops();
    register_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("tx_valid%0d", c), 32'(uart_tx_valid), 1);
      chk($sformatf("tx_data%0d", c), 32'(uart_tx_data), 32'hAB);
      chk($sformatf("tx_wbv%0d", c), 32'(wb_valid), 0);
      tick();
    end
    uart_tx_ready = 1;
    chk("tx_data_xfer", 32'(uart_tx_data), 32'hAB);
    tick();
    uart_tx_ready = 0;
    chk("tx_wb_valid", 32'(wb_valid), 1);
    chk("tx_wb_data", wb_data, 32'h77);
    chk("tx_valid_off", 32'(uart_tx_valid), 0);
    chk("tx_stall_off", 32'(stall), 0);
    tick();
    chk("tx_wb_pulse", 32'(wb_valid), 0);

    // Reset in the second MEM_WAIT cycle abandons the load
    MemRead = 1; valid_in = 1; RegWrite = 1; rdist = 5'd8; result = 32'h10;
    tick();
    clear_ops();
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mw_wbv", 32'(wb_valid), 0);
    chk("rst_mw_stall", 32'(stall), 0);
    chk("rst_mw_re", 32'(mem_re), 0);
    chk("rst_mw_wbd", wb_data, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_mw_late%0d", c), 32'(wb_valid), 0);
    end
    valid_in = 1; RegWrite = 1; rdist = 5'd6; result = 32'h55;
    tick();
    clear_ops();
    chk("post_rst_wbv", 32'(wb_valid), 1);
    chk("post_rst_wbd", wb_data, 32'h55);
    chk("post_rst_rd", 32'(rdist_wb), 6);

    // Reset during RX_WAIT, then a late rx byte is ignored
    UARTtoReg = 1; valid_in = 1; RegWrite = 1; rdist = 5'd10;
    tick();
    clear_ops();
    reset = 1;
    tick();
    reset = 0;
    uart_rx_valid = 1; uart_rx_data = 8'h99;
    tick();
    chk("rst_rx_wbv", 32'(wb_valid), 0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 0);
    tick();
    uart_rx_valid = 0;
    chk("rst_rx_wbv2", 32'(wb_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
